// File: rtl/bridge_pkg.sv
// Shared types and constants for the three-bus bridge arbiter.
// Code bit order is {open2To1, open1To2, open2To3, open3To2}.
package bridge_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_LEN_W   = 2;

    localparam logic [3:0] CODE_CLOSED     = 4'b0000;
    localparam logic [3:0] CODE_3TO2       = 4'b0001;
    localparam logic [3:0] CODE_2TO3       = 4'b0010;
    localparam logic [3:0] CODE_1TO2       = 4'b0100;
    localparam logic [3:0] CODE_1TO2_2TO3  = 4'b0110;
    localparam logic [3:0] CODE_2TO1       = 4'b1000;
    localparam logic [3:0] CODE_2TO1_3TO2  = 4'b1001;
    localparam logic [3:0] CODE_2TO1_2TO3  = 4'b1010;

    // Anything outside this list would short buses together or open both directions.
    function automatic logic code_legal(input logic [3:0] code);
        case (code)
            CODE_CLOSED, CODE_3TO2, CODE_2TO3, CODE_1TO2,
            CODE_1TO2_2TO3, CODE_2TO1, CODE_2TO1_3TO2, CODE_2TO1_2TO3:
                code_legal = 1'b1;
            default:
                code_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bridge_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr+1, with wrap.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [PTR_W:0]       shift;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   rot_win;

    // Rotate so ptr+1 lands on bit 0, isolate the lowest set bit, rotate back.
    // A shift of exactly NUM_REQ is a full rotation, so no modulo is needed.
    assign shift   = {1'b0, ptr} + (PTR_W+1)'(1);
    assign rot     = NUM_REQ'({elig, elig} >> shift);
    assign rot_win = rot & (~rot + NUM_REQ'(1));
    assign win     = NUM_REQ'(({rot_win, rot_win} << shift) >> NUM_REQ);
    assign valid   = |elig;

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter that hands the three-bus bridge to one requester at a time
// and holds the latched open code for len+1 cycles.
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0][3:0]         req_code,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic [NUM_REQ-1:0]              err,
    output logic                            open2To1,
    output logic                            open1To2,
    output logic                            open2To3,
    output logic                            open3To2,
    output logic                            busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [LEN_W-1:0]     count;
    logic [PTR_W-1:0]     last;
    logic [3:0]           opens;

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   illegal;
    logic [NUM_REQ-1:0]   win;
    logic                 win_valid;
    logic [3:0]           win_code;
    logic [LEN_W-1:0]     win_len;
    logic [PTR_W-1:0]     win_idx;

    always_comb begin
        elig    = '0;
        illegal = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = req[i] &  code_legal(req_code[i]);
            illegal[i] = req[i] & ~code_legal(req_code[i]);
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .elig  (elig),
        .ptr   (last),
        .win   (win),
        .valid (win_valid)
    );

    // The winner is one-hot, so OR-ing the masked fields selects its code/length/index.
    always_comb begin
        win_code = '0;
        win_len  = '0;
        win_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_code |= req_code[i];
                win_len  |= req_len[i];
                win_idx  |= PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            opens <= '0;
            count <= '0;
            last  <= PTR_W'(NUM_REQ - 1);
        end else begin
            done <= '0;
            err  <= '0;
            if (state == IDLE) begin
                err <= illegal;
                if (win_valid) begin
                    state <= ACTIVE;
                    busy  <= 1'b1;
                    gnt   <= win;
                    opens <= win_code;
                    count <= win_len;
                    last  <= win_idx;
                end
            end else if ((req & gnt) == '0) begin
                // Owner withdrew: close the bridge without signalling completion.
                state <= IDLE;
                busy  <= 1'b0;
                gnt   <= '0;
                opens <= '0;
                count <= '0;
            end else if (count == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                gnt   <= '0;
                opens <= '0;
                done  <= gnt;
            end else begin
                count <= count - LEN_W'(1);
            end
        end
    end

    assign open2To1 = opens[3];
    assign open1To2 = opens[2];
    assign open2To3 = opens[1];
    assign open3To2 = opens[0];

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: a cycle-by-cycle vector table followed by
// hand-written abort and mid-transfer reset sequences.
module tb_bridge_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [2:0][3:0]  req_code;
    logic [2:0][1:0]  req_len;
    logic [2:0]       gnt;
    logic [2:0]       done;
    logic [2:0]       err;
    logic             open2To1;
    logic             open1To2;
    logic             open2To3;
    logic             open3To2;
    logic             busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  req;
        logic [11:0] code;
        logic [5:0]  len;
        logic [13:0] want;
    } vec_t;

    vec_t vecs[$];

    bridge_arbiter #(
        .NUM_REQ (3),
        .LEN_W   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_code (req_code),
        .req_len  (req_len),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .open2To1 (open2To1),
        .open1To2 (open1To2),
        .open2To3 (open2To3),
        .open3To2 (open3To2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic r, input logic [2:0] rq,
                                input logic [11:0] code, input logic [5:0] len,
                                input logic [2:0] g, input logic [2:0] d, input logic [2:0] e,
                                input logic [3:0] o, input logic b);
        vec_t v;
        v.name = name;
        v.rst  = r;
        v.req  = rq;
        v.code = code;
        v.len  = len;
        v.want = {g, d, e, o, b};
        return v;
    endfunction

    // Inputs are held across one rising edge; outputs are sampled 1 time unit later.
    task automatic apply_stimulus(input logic r, input logic [2:0] rq,
                                  input logic [11:0] code, input logic [5:0] len);
        rst      = r;
        req      = rq;
        req_code = code;
        req_len  = len;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [13:0] want);
        logic [13:0] got;
        got = {gnt, done, err, open2To1, open1To2, open2To3, open3To2, busy};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got gnt=%b done=%b err=%b opens=%b busy=%b, want gnt=%b done=%b err=%b opens=%b busy=%b",
                     name, got[13:11], got[10:8], got[7:5], got[4:1], got[0],
                     want[13:11], want[10:8], want[7:5], want[4:1], want[0]);
        end
    endtask

    initial begin
        // Codes are packed {code2, code1, code0}; lengths {len2, len1, len0}.
        vecs.push_back(mk("reset",         1'b1, 3'b000, 12'h000, 6'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r31_cycle1",    1'b0, 3'b001, 12'h006, 6'h02, 3'b001, 3'b000, 3'b000, 4'b0110, 1'b1));
        vecs.push_back(mk("r31_cycle2",    1'b0, 3'b001, 12'h006, 6'h02, 3'b001, 3'b000, 3'b000, 4'b0110, 1'b1));
        vecs.push_back(mk("r31_cycle3",    1'b0, 3'b001, 12'h006, 6'h02, 3'b001, 3'b000, 3'b000, 4'b0110, 1'b1));
        vecs.push_back(mk("r31_done",      1'b0, 3'b001, 12'h006, 6'h02, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r31_idle",      1'b0, 3'b000, 12'h006, 6'h02, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_reset",     1'b1, 3'b000, 12'h821, 6'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_gnt0",      1'b0, 3'b111, 12'h821, 6'h00, 3'b001, 3'b000, 3'b000, 4'b0001, 1'b1));
        vecs.push_back(mk("r32_done0",     1'b0, 3'b111, 12'h821, 6'h00, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_gnt1",      1'b0, 3'b111, 12'h821, 6'h00, 3'b010, 3'b000, 3'b000, 4'b0010, 1'b1));
        vecs.push_back(mk("r32_done1",     1'b0, 3'b111, 12'h821, 6'h00, 3'b000, 3'b010, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_gnt2",      1'b0, 3'b111, 12'h821, 6'h00, 3'b100, 3'b000, 3'b000, 4'b1000, 1'b1));
        vecs.push_back(mk("r32_done2",     1'b0, 3'b111, 12'h821, 6'h00, 3'b000, 3'b100, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_gnt0_again",1'b0, 3'b111, 12'h821, 6'h00, 3'b001, 3'b000, 3'b000, 4'b0001, 1'b1));
        vecs.push_back(mk("r32_done0_again",1'b0,3'b111, 12'h821, 6'h00, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r32_idle",      1'b0, 3'b000, 12'h821, 6'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r33_err_gnt",   1'b0, 3'b110, 12'h1C0, 6'h00, 3'b100, 3'b000, 3'b010, 4'b0001, 1'b1));
        vecs.push_back(mk("r33_done",      1'b0, 3'b110, 12'h1C0, 6'h00, 3'b000, 3'b100, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("r33_err_repeat",1'b0, 3'b010, 12'h1C0, 6'h00, 3'b000, 3'b000, 3'b010, 4'b0000, 1'b0));
        vecs.push_back(mk("r33_idle",      1'b0, 3'b000, 12'h1C0, 6'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("closed_gnt",    1'b0, 3'b001, 12'h000, 6'h01, 3'b001, 3'b000, 3'b000, 4'b0000, 1'b1));
        vecs.push_back(mk("closed_hold",   1'b0, 3'b001, 12'h000, 6'h01, 3'b001, 3'b000, 3'b000, 4'b0000, 1'b1));
        vecs.push_back(mk("closed_done",   1'b0, 3'b001, 12'h000, 6'h01, 3'b000, 3'b001, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("closed_idle",   1'b0, 3'b000, 12'h000, 6'h01, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));
        vecs.push_back(mk("bad_codes",     1'b0, 3'b011, 12'h05F, 6'h00, 3'b000, 3'b000, 3'b011, 4'b0000, 1'b0));
        vecs.push_back(mk("bad_idle",      1'b0, 3'b000, 12'h05F, 6'h00, 3'b000, 3'b000, 3'b000, 4'b0000, 1'b0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].code, vecs[i].len);
            check_output(vecs[i].name, vecs[i].want);
        end

        // Owner 0 (len 3) drops its request during its second active cycle.
        apply_stimulus(1'b0, 3'b001, 12'h009, 6'h03);
        check_output("r34_active1", {3'b001, 3'b000, 3'b000, 4'b1001, 1'b1});
        apply_stimulus(1'b0, 3'b001, 12'h009, 6'h03);
        check_output("r34_active2", {3'b001, 3'b000, 3'b000, 4'b1001, 1'b1});
        apply_stimulus(1'b0, 3'b000, 12'h009, 6'h03);
        check_output("r34_abort", {3'b000, 3'b000, 3'b000, 4'b0000, 1'b0});
        apply_stimulus(1'b0, 3'b000, 12'h009, 6'h03);
        check_output("r34_no_late_done", {3'b000, 3'b000, 3'b000, 4'b0000, 1'b0});

        // Reset lands while requester 2 owns the bridge; priority returns to requester 0.
        apply_stimulus(1'b0, 3'b100, 12'h600, 6'h30);
        check_output("r35_active1", {3'b100, 3'b000, 3'b000, 4'b0110, 1'b1});
        apply_stimulus(1'b0, 3'b100, 12'h600, 6'h30);
        check_output("r35_active2", {3'b100, 3'b000, 3'b000, 4'b0110, 1'b1});
        apply_stimulus(1'b1, 3'b111, 12'h821, 6'h00);
        check_output("r35_reset", {3'b000, 3'b000, 3'b000, 4'b0000, 1'b0});
        apply_stimulus(1'b0, 3'b111, 12'h821, 6'h00);
        check_output("r35_first_gnt", {3'b001, 3'b000, 3'b000, 4'b0001, 1'b1});
        apply_stimulus(1'b0, 3'b000, 12'h821, 6'h00);
        check_output("r35_abort", {3'b000, 3'b000, 3'b000, 4'b0000, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
BRIDGE_ARBITER -- requirements
Module: bridge_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing the three-bus bridge.
REQ-002 Parameter LEN_W, default 2, width of the per-request hold length (transfer lasts len+1 cycles).
REQ-003 Port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port req  in  NUM_REQ  per-requester transfer request level.
REQ-006 Port req_code  in  NUM_REQ x 4  per-requester bridge code, bit order {open2To1, open1To2, open2To3, open3To2}.
REQ-007 Port req_len  in  NUM_REQ x LEN_W  per-requester hold length minus one.
REQ-008 Port gnt  out  NUM_REQ  one-hot grant, high for every cycle the owner's code drives the bridge.
REQ-009 Port done  out  NUM_REQ  one-cycle pulse: the owner's transfer completed normally.
REQ-010 Port err  out  NUM_REQ  one-cycle pulse: request rejected for an illegal code.
REQ-011 Ports open2To1, open1To2, open2To3, open3To2  out  1 each  registered bridge controls.
REQ-012 Port busy  out  1  high in ACTIVE state.

Function
REQ-013 The legal codes SHALL be exactly 0000, 0001, 0010, 0100, 0110, 1000, 1001, 1010; all other codes are illegal.
REQ-014 The FSM SHALL have states IDLE and ACTIVE only.
REQ-015 In IDLE, eligible requesters SHALL be those with req=1 and a legal code.
REQ-016 The winner SHALL be the first eligible index scanning upward, with wrap, from (last granted + 1) mod NUM_REQ.
REQ-017 When IDLE has a winner in cycle N, then from cycle N+1: state=ACTIVE, gnt one-hot on the winner, opens=winner code, and counter=winner req_len. Code and length SHALL be latched at grant and ignored afterwards.
REQ-018 In ACTIVE, the counter SHALL decrement each cycle. The opens SHALL stay asserted for exactly req_len+1 cycles.
REQ-019 In the cycle after the counter=0 ACTIVE cycle:
- state=IDLE
- gnt=0
- opens=0000
- done pulses on the owner
REQ-020 At least one all-closed IDLE cycle SHALL separate consecutive grants; back-to-back grants to the same or different requesters are otherwise allowed.
REQ-021 The last-granted pointer SHALL update only when a grant is issued.
REQ-022 In IDLE, every requester with req=1 and an illegal code SHALL get err=1 that cycle and is not granted. err repeats each IDLE cycle while the request persists.
REQ-023 If the owner drops req while ACTIVE, the block SHALL abort: the next cycle is IDLE with opens=0000 and gnt=0, and no done pulse is issued.
REQ-024 Requests from non-owners during ACTIVE SHALL be ignored (no err, no grant) until IDLE.
REQ-025 A requester whose code is 0000 SHALL be granted normally and hold the bridge closed for len+1 cycles.

Reset
REQ-026 On rst=1 at a clock edge, the outputs SHALL reset as follows:
- state=IDLE
- gnt=0, done=0, err=0
- opens=0000
- busy=0
- counter=0
- last-granted pointer=NUM_REQ-1, so requester 0 has first priority
REQ-027 rst SHALL override any in-progress transfer, and no done pulse SHALL follow a reset.

Structure
REQ-028 Package bridge_pkg SHALL hold:
- the state enum {IDLE, ACTIVE}
- the 4-bit legal-code constants
- the default NUM_REQ and LEN_W localparams
REQ-029 Round-robin selection SHALL be a sub-module rr_picker that is purely combinational (inputs: eligible vector, pointer; outputs: one-hot winner, valid).
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 Requester 0 is the sole requester with code 0110, len=2, from reset. Required: opens 0110 and gnt=001 for cycles 1-3; cycle 4 has opens=0000 and done=001.
REQ-032 All three requesters hold legal codes continuously with len=0. Required: grant order 0,1,2,0 with one idle cycle between grants.
REQ-033 Requester 1 holds code 1100 (illegal) and requester 2 holds code 0001. Required: err=010 in the IDLE cycle, then gnt=100 with opens 0001.
REQ-034 Requester 0 has len=3 and drops req in its second ACTIVE cycle. Required: the next cycle has opens=0000, gnt=0 and done=0.
REQ-035 Assert rst mid-ACTIVE on requester 2. Required: the next cycle has all outputs zero, and the subsequent grant goes to requester 0 first.
